svc_rv_io_uart_tx: RTL and testbench

// MMIO UART transmitter on the SoC io_* bus, downstream of svc_rv_soc_bram.
// It replaces or sits beside the io BRAM in the same address window.
// CPU stores push bytes into a small TX FIFO. A baud-rate FSM serialises them as 8N1 frames on txd.

---
 rtl/svc_rv_io_uart_tx.sv | 259 +++++++++++++++++++++++++
 tb/tb_svc_rv_io_uart_tx.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_io_uart_tx.sv
// rtl/svc_rv_io_uart_tx.sv - MMIO 8N1 UART transmitter with TX FIFO on the io_* bus
//
// Purpose:
//   CPU stores to TXDATA queue bytes in a small FIFO. A baud-rate FSM pops
//   them and serialises each one as an 8N1 frame on txd. STATUS and BAUD_DIV
//   are readable with the same one-cycle registered read latency as the io
//   BRAM that this block replaces or sits beside.
//
// Register map (word index = addr[3:2]):
//   0 TXDATA   write pushes wdata[7:0] (needs wstrb[0]); reads 0
//   1 STATUS   {28'b0, ovf, busy, empty, full}; write wdata[3]=1 clears ovf
//   2 BAUD_DIV [15:0] clk cycles per bit; write needs wstrb[1:0]==2'b11,
//              0 is stored as 1; takes effect at the next frame start
//   3 reserved reads 0, writes ignored
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   io_ren     read strobe
//   io_raddr   read byte address, only [3:2] decoded
//   io_rdata   read data, registered on the io_ren edge and held
//   io_wen     write strobe
//   io_waddr   write byte address, only [3:2] decoded
//   io_wdata   write data
//   io_wstrb   write byte strobes
//   txd        serial output, idle high, driven from a flop
//   busy       FSM not idle or FIFO non-empty

module svc_rv_io_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  output logic        txd,
  output logic        busy
);

  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam int            CW        = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   RESET_DIV = 16'(CLKS_PER_BIT);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t        state, state_d;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty, fifo_full;

  logic          ovf;
  logic [15:0]   baud_div;

  logic [15:0]   cur_div, cur_div_d;
  logic [15:0]   baud_cnt, baud_cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          pop;

  logic          wr_txdata, wr_status, wr_baud, push_ok;
  logic [31:0]   rd_mux;
  logic          unused_bits;

  // Only the word index is decoded; the rest of the bus is deliberately ignored.
  assign unused_bits = ^{io_raddr[31:4], io_raddr[1:0], io_waddr[31:4],
                         io_waddr[1:0], io_wdata[31:16], io_wstrb[3:2]};

  assign wr_txdata  = io_wen && (io_waddr[3:2] == REG_TXDATA) && io_wstrb[0];
  assign wr_status  = io_wen && (io_waddr[3:2] == REG_STATUS) && io_wstrb[0];
  assign wr_baud    = io_wen && (io_waddr[3:2] == REG_BAUD) && (io_wstrb[1:0] == 2'b11);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);

  // A full FIFO still accepts a byte when the FSM pops in the same cycle.
  assign push_ok    = wr_txdata && (!fifo_full || pop);

  assign busy       = (state != ST_IDLE) || !fifo_empty;
  assign txd        = txd_q;

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= io_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------ control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      baud_div <= RESET_DIV;
    end else begin
      if (wr_txdata && !push_ok) begin
        ovf <= 1'b1;
      end else if (wr_status && io_wdata[3]) begin
        ovf <= 1'b0;
      end
      if (wr_baud) begin
        baud_div <= (io_wdata[15:0] == 16'd0) ? 16'd1 : io_wdata[15:0];
      end
    end
  end

  // ---------------------------------------------------------- read port
  always_comb begin
    rd_mux = '0;
    case (io_raddr[3:2])
      REG_STATUS: rd_mux = {28'd0, ovf, busy, fifo_empty, fifo_full};
      REG_BAUD:   rd_mux = {16'd0, baud_div};
      default:    rd_mux = '0;
    endcase
  end

  // Status is sampled before any same-edge write lands, so a simultaneous
  // read/write of STATUS returns the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_rdata <= '0;
    end else if (io_ren) begin
      io_rdata <= rd_mux;
    end
  end

  // ------------------------------------------------------------ TX FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_div  <= RESET_DIV;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      state    <= state_d;
      cur_div  <= cur_div_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

  // baud_cnt counts down from div-1; reaching 0 marks the last cycle of a bit.
  // The divisor is latched per frame so BAUD_DIV writes never stretch a frame
  // already on the wire.
  always_comb begin
    state_d    = state;
    cur_div_d  = cur_div;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift_q;
    txd_d      = txd_q;
    pop        = 1'b0;

    case (state)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_mem[rd_ptr];
          cur_div_d  = baud_div;
          baud_cnt_d = baud_div - 16'd1;
          txd_d      = 1'b0;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        if (baud_cnt == 16'd0) begin
          baud_cnt_d = cur_div - 16'd1;
          bit_idx_d  = 3'd0;
          txd_d      = shift_q[0];
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt - 16'd1;
        end
      end

      ST_DATA: begin
        if (baud_cnt == 16'd0) begin
          baud_cnt_d = cur_div - 16'd1;
          if (bit_idx == 3'd7) begin
            txd_d   = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            txd_d     = shift_q[bit_idx + 3'd1];
          end
        end else begin
          baud_cnt_d = baud_cnt - 16'd1;
        end
      end

      ST_STOP: begin
        if (baud_cnt == 16'd0) begin
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            pop        = 1'b1;
            shift_d    = fifo_mem[rd_ptr];
            cur_div_d  = baud_div;
            baud_cnt_d = baud_div - 16'd1;
            txd_d      = 1'b0;
            state_d    = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt - 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_svc_rv_io_uart_tx.sv
// tb/tb_svc_rv_io_uart_tx.sv - self-checking bench for svc_rv_io_uart_tx
module tb_svc_rv_io_uart_tx;

  localparam int LOG_N = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_ren = 1'b0;
  logic [31:0] io_raddr = '0;
  logic [31:0] io_rdata;
  logic        io_wen = 1'b0;
  logic [31:0] io_waddr = '0;
  logic [31:0] io_wdata = '0;
  logic [3:0]  io_wstrb = '0;
  logic        txd;
  logic        busy;

  svc_rv_io_uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_ren   (io_ren),
    .io_raddr (io_raddr),
    .io_rdata (io_rdata),
    .io_wen   (io_wen),
    .io_waddr (io_waddr),
    .io_wdata (io_wdata),
    .io_wstrb (io_wstrb),
    .txd      (txd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   first_bad = -1;
  logic txd_log  [LOG_N];
  logic busy_log [LOG_N];
  bit   exp_q[$];

  // txd_log[k] / busy_log[k] hold the output value after rising edge number k.
  always @(posedge clk) edge_cnt = edge_cnt + 1;
  always @(negedge clk) begin
    if (edge_cnt < LOG_N) begin
      txd_log[edge_cnt]  = txd;
      busy_log[edge_cnt] = busy;
    end
  end

  // Reference waveform of one 8N1 frame: start, 8 data bits LSB first, stop.
  function automatic void add_frame(input logic [7:0] b, input int d);
    for (int k = 0; k < d; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < d; k++) exp_q.push_back(b[i]);
    for (int k = 0; k < d; k++) exp_q.push_back(1'b1);
  endfunction

  function automatic int stream_errs(input int s);
    int bad;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if ((s + i >= LOG_N) || (txd_log[s + i] !== logic'(exp_q[i]))) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    return bad;
  endfunction

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int e);
    io_wen   = 1'b1;
    io_waddr = addr;
    io_wdata = data;
    io_wstrb = strb;
    @(posedge clk); #1;
    io_wen   = 1'b0;
    io_wstrb = 4'b0000;
    e = edge_cnt;
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
    io_ren   = 1'b1;
    io_raddr = addr;
    @(posedge clk); #1;
    io_ren = 1'b0;
    data   = io_rdata;
  endtask

  task automatic wait_past(input int e);
    while (edge_cnt <= e) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int          ev;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (io_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", io_rdata); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    read_reg(32'h4, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h want 2", d); end
    read_reg(32'h8, d);
    checks++; if (d !== 32'd16) begin errors++; $display("FAIL reset_baud: got %0d want 16", d); end
    read_reg(32'h0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL txdata_read: got %h want 0", d); end
    write_reg(32'hC, 32'hFFFF_FFFF, 4'b1111, ev);
    read_reg(32'hC, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reserved_read: got %h want 0", d); end
    read_reg(32'h8, d);
    checks++; if (d !== 32'd16) begin errors++; $display("FAIL reserved_write_baud: got %0d want 16", d); end
  endtask

  task automatic test_single_byte();
    int e0, s, bad;
    write_reg(32'h8, 32'd4, 4'b0011, e0);
    write_reg(32'h0, 32'h55, 4'b0001, e0);
    s = e0 + 1;
    exp_q.delete();
    add_frame(8'h55, 4);
    wait_past(s + 41);
    bad = stream_errs(s);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_frame: %0d of %0d txd samples wrong, first at %0d got %b want %b",
               bad, exp_q.size(), first_bad, txd_log[s + first_bad], exp_q[first_bad]);
    end
    checks++; if (busy_log[s + 39] !== 1'b1) begin errors++; $display("FAIL single_busy_stop: got %b want 1", busy_log[s + 39]); end
    checks++;
    if (busy_log[s + 40] !== 1'b0 || txd_log[s + 40] !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: busy %b txd %b want busy 0 txd 1", busy_log[s + 40], txd_log[s + 40]);
    end
  endtask

  task automatic test_back_to_back();
    int          e0, ev, s, bad;
    logic [31:0] d;
    write_reg(32'h8, 32'd2, 4'b0011, ev);
    write_reg(32'h0, 32'hA5, 4'b0001, e0);
    write_reg(32'h0, 32'h3C, 4'b0001, ev);
    s = e0 + 1;
    exp_q.delete();
    add_frame(8'hA5, 2);
    add_frame(8'h3C, 2);
    read_reg(32'h4, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL b2b_status_queued: got %h want 4", d); end
    wait_past(s + 23);
    read_reg(32'h4, d);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL b2b_status_popped: got %h want 6", d); end
    wait_past(s + 41);
    bad = stream_errs(s);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_frames: %0d of %0d txd samples wrong, first at %0d got %b want %b",
               bad, exp_q.size(), first_bad, txd_log[s + first_bad], exp_q[first_bad]);
    end
    checks++;
    if (busy_log[s + 40] !== 1'b0 || txd_log[s + 40] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: busy %b txd %b want busy 0 txd 1", busy_log[s + 40], txd_log[s + 40]);
    end
  endtask

  task automatic test_random_stream();
    int          e0, ev, s, bad, d, n, len;
    logic [31:0] a, w, rd;
    logic [7:0]  b;
    for (int it = 0; it < 4; it++) begin
      d = int'($urandom_range(1, 5));
      n = int'($urandom_range(1, 4));
      a = $urandom(); a[3:0] = 4'h8;
      write_reg(a, 32'(d), 4'b0011, ev);
      a = $urandom(); a[3:0] = 4'h8;
      read_reg(a, rd);
      checks++; if (rd !== 32'(d)) begin errors++; $display("FAIL rand_baud_readback: got %0d want %0d", rd, d); end
      exp_q.delete();
      s = 0;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom());
        w = $urandom(); w[7:0] = b;
        a = $urandom(); a[3:0] = 4'h0;
        write_reg(a, w, 4'b0001, e0);
        if (k == 0) s = e0 + 1;
        add_frame(b, d);
      end
      len = exp_q.size();
      wait_past(s + len + 1);
      bad = stream_errs(s);
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand_stream it%0d div %0d bytes %0d: %0d samples wrong, first at %0d got %b want %b",
                 it, d, n, bad, first_bad, txd_log[s + first_bad], exp_q[first_bad]);
      end
      checks++;
      if (busy_log[s + len] !== 1'b0 || txd_log[s + len] !== 1'b1) begin
        errors++;
        $display("FAIL rand_idle it%0d: busy %b txd %b want busy 0 txd 1", it, busy_log[s + len], txd_log[s + len]);
      end
      read_reg(32'h4, rd);
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL rand_status_end it%0d: got %h want 2", it, rd); end
    end
  endtask

  task automatic test_overflow();
    int          e0, ev, s, bad, len;
    logic [31:0] d;
    logic [7:0]  b;
    write_reg(32'h8, 32'd100, 4'b0011, ev);
    exp_q.delete();
    e0 = 0;
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom());
      write_reg(32'h0, {24'd0, b}, 4'b0001, ev);
      if (k == 0) e0 = ev;
      if (k < 5) add_frame(b, 100);
    end
    s = e0 + 1;
    read_reg(32'h4, d);
    checks++; if (d !== 32'hD) begin errors++; $display("FAIL ovf_status: got %h want d", d); end
    io_ren   = 1'b1; io_raddr = 32'h4;
    io_wen   = 1'b1; io_waddr = 32'h4; io_wdata = 32'h8; io_wstrb = 4'b0001;
    @(posedge clk); #1;
    io_ren = 1'b0; io_wen = 1'b0; io_wstrb = 4'b0000;
    d = io_rdata;
    checks++; if (d !== 32'hD) begin errors++; $display("FAIL ovf_rw_prewrite: got %h want d", d); end
    read_reg(32'h4, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL ovf_cleared: got %h want 5", d); end
    len = exp_q.size();
    wait_past(s + len + 1);
    bad = stream_errs(s);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ovf_frames: %0d of %0d txd samples wrong, first at %0d got %b want %b",
               bad, len, first_bad, txd_log[s + first_bad], exp_q[first_bad]);
    end
    checks++;
    if (busy_log[s + len] !== 1'b0 || txd_log[s + len] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_dropped_not_sent: busy %b txd %b want busy 0 txd 1", busy_log[s + len], txd_log[s + len]);
    end
  endtask

  task automatic test_div_edge();
    int          e0, ev, s, bad, len;
    logic [31:0] d;
    logic [7:0]  b1, b2;
    write_reg(32'h8, 32'd0, 4'b0011, ev);
    read_reg(32'h8, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL div_zero_readback: got %0d want 1", d); end
    b1 = 8'($urandom());
    b2 = 8'($urandom());
    exp_q.delete();
    add_frame(b1, 1);
    add_frame(b2, 8);
    write_reg(32'h0, {24'd0, b1}, 4'b0001, e0);
    s = e0 + 1;
    read_reg(32'h8, d);
    write_reg(32'h8, 32'd8, 4'b0011, ev);
    write_reg(32'h0, {24'd0, b2}, 4'b0001, ev);
    read_reg(32'h8, d);
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL div_midframe_readback: got %0d want 8", d); end
    write_reg(32'h8, 32'h1234, 4'b0001, ev);
    read_reg(32'h8, d);
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL div_partial_strb: got %0d want 8", d); end
    len = exp_q.size();
    wait_past(s + len + 1);
    bad = stream_errs(s);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL div_frames: %0d of %0d txd samples wrong, first at %0d got %b want %b",
               bad, len, first_bad, txd_log[s + first_bad], exp_q[first_bad]);
    end
    checks++;
    if (busy_log[s + len] !== 1'b0 || txd_log[s + len] !== 1'b1) begin
      errors++;
      $display("FAIL div_idle: busy %b txd %b want busy 0 txd 1", busy_log[s + len], txd_log[s + len]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int          e0, ev, s, r, lows;
    logic [31:0] d;
    write_reg(32'h8, 32'd4, 4'b0011, ev);
    read_reg(32'h8, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL rst_pre_baud: got %0d want 4", d); end
    write_reg(32'h0, 32'h00, 4'b0001, e0);
    write_reg(32'h0, 32'h5A, 4'b0001, ev);
    s = e0 + 1;
    wait_past(s + 10);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL rst_pre_data_low: got %b want 0", txd); end
    rst_n = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_async_txd: got %b want 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    checks++; if (io_rdata !== 32'd0) begin errors++; $display("FAIL rst_async_rdata: got %h want 0", io_rdata); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    r = edge_cnt;
    read_reg(32'h4, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL rst_post_status: got %h want 2", d); end
    read_reg(32'h8, d);
    checks++; if (d !== 32'd16) begin errors++; $display("FAIL rst_post_baud: got %0d want 16", d); end
    wait_past(r + 200);
    lows = 0;
    for (int i = 0; i < 200; i++) if (txd_log[r + i] !== 1'b1) lows++;
    checks++; if (lows != 0) begin errors++; $display("FAIL rst_no_residual: %0d non-idle txd samples, want 0", lows); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_random_stream();
    test_overflow();
    test_div_edge();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
